bus_load_regs: RTL
==================

// Module: bus_load_regs
// PURPOSE
//  Receiving end of the global bus: captures g_bus1/g_bus2 into datapath destination registers
//  (PC, MAR, MDR, IR, HI/LO) under per-register load strobes from the control FSM.
//  Also owns the memory-write handshake: holds MAR/MDR stable toward memory until acknowledged.
//  Sits between the global bus driver and the PC, instruction decode, HI/LO and memory interface.
// PARAMETERS
//  WIDTH      32     data/address width of bus and all registers
//  PC_RESET   32'h0  PC value after reset
//  TIMEOUT    16     max cycles in WRITE waiting for mem_ready before abort (>=2)
// PORTS
//  Clk          in   1      system clock, rising edge
//  Reset        in   1      asynchronous, active-high reset
//  g_bus1       in   WIDTH  primary global bus
//  g_bus2       in   WIDTH  secondary global bus (ALU second operand / HI half)
//  ld_pc        in   1      capture g_bus1 into PC
//  ld_mar       in   1      capture g_bus1 into MAR
//  ld_mdr       in   1      capture g_bus1 into MDR
//  ld_ir        in   1      capture g_bus1 into IR
//  ld_hilo      in   1      capture g_bus1 into LO and g_bus2 into HI
//  mem_wr_start in   1      request memory write of MDR to address MAR
//  mem_ready    in   1      memory acknowledges write
//  pc_out, mar_out, mdr_out, ir_out, hi_out, lo_out  out  WIDTH  register contents
//  mem_addr     out  WIDTH  write address (= MAR)
//  mem_wdata    out  WIDTH  write data (= MDR)
//  mem_we       out  1      write request, high only in WRITE
//  mem_busy     out  1      high in WRITE and DONE
//  mem_done     out  1      1-cycle pulse: write acknowledged
//  mem_err      out  1      1-cycle pulse: write timed out
//  ld_conflict  out  1      1-cycle registered pulse: illegal load/start request rejected
// BEHAVIOUR
//  Reset (async, immediate): PC=PC_RESET; MAR/MDR/IR/HI/LO=0; FSM=IDLE; timeout count=0;
//   mem_we/mem_busy/mem_done/mem_err/ld_conflict=0.
//  Loads: registered on rising Clk; new value visible on outputs the cycle after the strobe.
//   Any combination of strobes is legal (bus broadcast); each selected register captures.
//  Interlock: while mem_busy=1, ld_mar and ld_mdr are ignored (register unchanged) and
//   ld_conflict pulses next cycle; ld_pc/ld_ir/ld_hilo are always honoured.
//  FSM IDLE: mem_wr_start -> WRITE, counter cleared. If ld_mar/ld_mdr and mem_wr_start in same
//   cycle, loads capture first; the write uses the new values.
//  FSM WRITE: mem_we=1, mem_addr=mar_out, mem_wdata=mdr_out, counter increments each cycle.
//   mem_ready=1 -> DONE (may occur on first WRITE cycle; latency start->done pulse = 2 cycles min).
//   counter reaches TIMEOUT-1 with no mem_ready -> IDLE, mem_err pulses 1 cycle. mem_ready on
//   that same final cycle wins (-> DONE, no error).
//  FSM DONE: mem_we=0, mem_done=1 for exactly this cycle -> IDLE unconditionally.
//  mem_wr_start outside IDLE: ignored, ld_conflict pulses.
//  mem_ready outside WRITE: ignored.
//  Reset mid-write: immediate return to IDLE, mem_we drops asynchronously, no done/err pulse.
// TESTING
//  Reset -> pc_out=PC_RESET, all other registers 0, mem_we=0, mem_busy=0.
//  g_bus1=32'hDEAD_BEEF, g_bus2=32'h1234_5678, ld_hilo+ld_ir one cycle -> lo=DEADBEEF, hi=12345678, ir=DEADBEEF next cycle.
//  ld_mar(g_bus1=0x100)+ld_mdr(g_bus1=0xAB) then start, mem_ready after 3 cycles -> mem_addr=0x100, wdata=0xAB, one mem_done pulse.
//  During WRITE assert ld_mdr with g_bus1=0x55 -> mdr_out unchanged, ld_conflict pulse, mem_wdata stable.
//  Start with mem_ready never asserted -> mem_we high exactly TIMEOUT cycles, one mem_err pulse, back to IDLE.
//  Assert Reset 2 cycles into WRITE -> mem_we=0 immediately, no mem_done/mem_err, registers at reset values.

Source files
------------

// File: rtl/bus_load_regs.sv
// Destination-register bank on the global bus plus the memory-write handshake.
// MAR/MDR are frozen while a write is in flight so memory sees a stable address/data pair.
module bus_load_regs #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter int unsigned      TIMEOUT  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] g_bus1,
  input  logic [WIDTH-1:0] g_bus2,
  input  logic             ld_pc,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             ld_ir,
  input  logic             ld_hilo,
  input  logic             mem_wr_start,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] mar_out,
  output logic [WIDTH-1:0] mdr_out,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err,
  output logic             ld_conflict
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              conflict_q, conflict_d;
  logic [WIDTH-1:0]  pc_q, mar_q, mdr_q, ir_q, hi_q, lo_q;

  assign mem_busy = (state_q != StIdle);
  assign mem_we   = (state_q == StWrite);
  assign mem_done = (state_q == StDone);
  assign mem_err  = err_q;
  assign ld_conflict = conflict_q;

  assign pc_out    = pc_q;
  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign ir_out    = ir_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q  <= PC_RESET;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (ld_pc) pc_q <= g_bus1;
      if (ld_ir) ir_q <= g_bus1;
      if (ld_hilo) begin
        lo_q <= g_bus1;
        hi_q <= g_bus2;
      end
      // Address/data held for the whole write; a load in IDLE with start lands first.
      if (ld_mar && !mem_busy) mar_q <= g_bus1;
      if (ld_mdr && !mem_busy) mdr_q <= g_bus1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    conflict_d = (mem_busy && (ld_mar || ld_mdr)) || (mem_wr_start && state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (mem_wr_start) begin
          state_d = StWrite;
          cnt_d   = '0;
        end
      end
      StWrite: begin
        // An acknowledge on the final allowed cycle still counts as success.
        if (mem_ready) begin
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      conflict_q <= conflict_d;
    end
  end

endmodule
